pl_hazard_ctrl: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage RISC-V core. Drives the write-enables
//  and squash controls of PC, the IF/ID register (wpcir) and the ID/EX register.

---
 rtl/pl_hazard_ctrl_if.sv | 39 +++
 rtl/pl_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pl_hazard_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pl_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side drives the hazard sources; the controller drives enables and counters.
interface pl_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_ready;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic             d_use_rs1;
    logic             d_use_rs2;
    logic [4:0]       e_rd;
    logic             e_wreg;
    logic             e_m2reg;
    logic             e_is_md;
    logic             e_br_taken;
    logic             wpc;
    logic             wpcir;
    logic             we_de;
    logic             ir_flush;
    logic             de_bubble;
    logic             md_start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output imem_ready, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
               e_rd, e_wreg, e_m2reg, e_is_md, e_br_taken,
        input  wpc, wpcir, we_de, ir_flush, de_bubble, md_start, md_busy,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_ready, d_rs1, d_rs2, d_use_rs1, d_use_rs2,
               e_rd, e_wreg, e_m2reg, e_is_md, e_br_taken,
        output wpc, wpcir, we_de, ir_flush, de_bubble, md_start, md_busy,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pl_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: PC, IF/ID and ID/EX enables and squashes,
// mul/div EX occupancy sequencing, and saturating stall/flush performance counters.
module pl_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             clr,
    pl_hazard_ctrl_if.slave  hz
);
    // Freeze counter only needs to hold MD_CYCLES-2.
    localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES - 1) : 1;

    typedef enum logic {RUN, MD} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             load_use, br_fire;
    logic             wpc, wpcir, we_de, ir_flush, de_bubble, md_start, md_busy;

    assign load_use = hz.e_m2reg && hz.e_wreg && (hz.e_rd != 5'd0) &&
                      ((hz.d_use_rs1 && (hz.d_rs1 == hz.e_rd)) ||
                       (hz.d_use_rs2 && (hz.d_rs2 == hz.e_rd)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wpc       = 1'b0;
        wpcir     = 1'b0;
        we_de     = 1'b0;
        ir_flush  = 1'b0;
        de_bubble = 1'b0;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        br_fire   = 1'b0;
        if (clr) begin
            ir_flush  = 1'b1;
            de_bubble = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
        end else if (state_q == MD && cnt_q != '0) begin
            md_busy = 1'b1;
            cnt_d   = cnt_q - CW'(1);
        end else begin
            // Release cycle of MD lands here too; the mul/div is still in EX so it must not restart.
            state_d = RUN;
            if (hz.e_br_taken) begin
                wpc       = 1'b1;
                wpcir     = 1'b1;
                we_de     = 1'b1;
                ir_flush  = 1'b1;
                de_bubble = 1'b1;
                br_fire   = 1'b1;
            end else if (state_q == RUN && hz.e_is_md) begin
                md_start = 1'b1;
                cnt_d    = CW'(MD_CYCLES - 2);
                state_d  = MD;
            end else if (load_use) begin
                we_de     = 1'b1;
                de_bubble = 1'b1;
            end else if (!hz.imem_ready) begin
                wpcir    = 1'b1;
                ir_flush = 1'b1;
                we_de    = 1'b1;
            end else begin
                wpc   = 1'b1;
                wpcir = 1'b1;
                we_de = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!wpcir && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (br_fire && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.wpc       = wpc;
    assign hz.wpcir     = wpcir;
    assign hz.we_de     = we_de;
    assign hz.ir_flush  = ir_flush;
    assign hz.de_bubble = de_bubble;
    assign hz.md_start  = md_start;
    assign hz.md_busy   = md_busy;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Bench for pl_hazard_ctrl: two instances (32-bit and 4-bit counters) on shared stimulus,
// checked against an age-based model of mul/div occupancy and the priority rules.
module tb_pl_hazard_ctrl;
    localparam int MDC = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       imem_ready, d_use_rs1, d_use_rs2, e_wreg, e_m2reg, e_is_md, e_br_taken;
    logic [4:0] d_rs1, d_rs2, e_rd;

    always #5 clk = ~clk;

    pl_hazard_ctrl_if #(.CNT_W(32)) if0 ();
    pl_hazard_ctrl_if #(.CNT_W(4))  if1 ();

    assign if0.imem_ready = imem_ready;  assign if1.imem_ready = imem_ready;
    assign if0.d_rs1      = d_rs1;       assign if1.d_rs1      = d_rs1;
    assign if0.d_rs2      = d_rs2;       assign if1.d_rs2      = d_rs2;
    assign if0.d_use_rs1  = d_use_rs1;   assign if1.d_use_rs1  = d_use_rs1;
    assign if0.d_use_rs2  = d_use_rs2;   assign if1.d_use_rs2  = d_use_rs2;
    assign if0.e_rd       = e_rd;        assign if1.e_rd       = e_rd;
    assign if0.e_wreg     = e_wreg;      assign if1.e_wreg     = e_wreg;
    assign if0.e_m2reg    = e_m2reg;     assign if1.e_m2reg    = e_m2reg;
    assign if0.e_is_md    = e_is_md;     assign if1.e_is_md    = e_is_md;
    assign if0.e_br_taken = e_br_taken;  assign if1.e_br_taken = e_br_taken;

    pl_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(32)) u0 (.clk(clk), .clr(clr), .hz(if0.slave));
    pl_hazard_ctrl #(.MD_CYCLES(MDC), .CNT_W(4))  u1 (.clk(clk), .clr(clr), .hz(if1.slave));

    int     checks = 0;
    int     errors = 0;
    // md_age: 0 = no mul/div in flight, else cycles since md_start.
    int     md_age = 0;
    longint st32 = 0, fl32 = 0, st4 = 0, fl4 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat_inc(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v >= m) ? m : v + 1;
    endfunction

    // Evaluate one cycle at negedge against the model, then advance over the posedge.
    task automatic cycle();
        logic [6:0] e;  // {wpc,wpcir,we_de,ir_flush,de_bubble,md_start,md_busy}
        logic [6:0] o0, o1;
        bit lu, brf;
        int nxt;
        @(negedge clk);
        lu  = e_m2reg && e_wreg && (e_rd != 0) &&
              ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
        brf = 0;
        nxt = 0;
        if (clr)                              e = 7'b0001100;
        else if (md_age > 0 && md_age < MDC-1) begin e = 7'b0000001; nxt = md_age + 1; end
        else if (e_br_taken)                 begin e = 7'b1111100; brf = 1; end
        else if (md_age == 0 && e_is_md)     begin e = 7'b0000010; nxt = 1; end
        else if (lu)                          e = 7'b0010100;
        else if (!imem_ready)                 e = 7'b0111000;
        else                                  e = 7'b1110000;
        o0 = {if0.wpc, if0.wpcir, if0.we_de, if0.ir_flush, if0.de_bubble, if0.md_start, if0.md_busy};
        o1 = {if1.wpc, if1.wpcir, if1.we_de, if1.ir_flush, if1.de_bubble, if1.md_start, if1.md_busy};
        chk("ctl32", 64'(o0), 64'(e));
        chk("ctl4", 64'(o1), 64'(e));
        chk("stall32", 64'(if0.stall_cnt), 64'(st32));
        chk("flush4", 64'(if1.flush_cnt), 64'(fl4));
        if (clr) begin
            st32 = 0; fl32 = 0; st4 = 0; fl4 = 0;
        end else begin
            if (!e[5]) begin st32 = sat_inc(st32, 32); st4 = sat_inc(st4, 4); end
            if (brf)   begin fl32 = sat_inc(fl32, 32); fl4 = sat_inc(fl4, 4); end
        end
        md_age = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; imem_ready = 1; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
        e_rd = 0; e_wreg = 0; e_m2reg = 0; e_is_md = 0; e_br_taken = 0;
    endtask

    task automatic set_lu();
        e_m2reg = 1; e_wreg = 1; e_rd = 5; d_rs1 = 5; d_use_rs1 = 1;
    endtask

    initial begin
        idle();
        clr = 1;
        @(posedge clk); #1;
        cycle();
        cycle();
        chk("rst_stall", 64'(if0.stall_cnt), 64'd0);
        chk("rst_flush", 64'(if0.flush_cnt), 64'd0);

        // Load-use: one stall cycle, then e_rd=0 gives none
        idle(); set_lu(); cycle();
        chk("lu_stall", 64'(if0.stall_cnt), 64'd1);
        e_rd = 0; d_rs1 = 0; cycle();
        chk("lu_x0_stall", 64'(if0.stall_cnt), 64'd1);

        // Mul/div: 3 freeze cycles then release
        idle(); e_is_md = 1;
        repeat (MDC) cycle();
        chk("md_stall", 64'(if0.stall_cnt), 64'd4);
        idle(); cycle();

        // Branch beats load-use
        idle(); set_lu(); e_br_taken = 1; cycle();
        chk("br_flush", 64'(if0.flush_cnt), 64'd1);
        chk("br_stall", 64'(if0.stall_cnt), 64'd4);

        // Imem wait two cycles
        idle(); imem_ready = 0; cycle(); cycle();
        chk("imem_stall", 64'(if0.stall_cnt), 64'd4);

        // Reset during MD
        idle(); e_is_md = 1; cycle();
        clr = 1; cycle();
        idle(); cycle();
        chk("clrmd_stall", 64'(if0.stall_cnt), 64'd0);
        chk("clrmd_flush", 64'(if0.flush_cnt), 64'd0);

        // Saturation of the narrow counter
        idle(); set_lu();
        repeat (20) cycle();
        chk("sat4", 64'(if1.stall_cnt), 64'd15);
        chk("sat32", 64'(if0.stall_cnt), 64'd20);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            clr        = ($urandom_range(0, 49) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            d_rs1      = 5'($urandom_range(0, 3));
            d_rs2      = 5'($urandom_range(0, 3));
            e_rd       = 5'($urandom_range(0, 3));
            d_use_rs1  = 1'($urandom);
            d_use_rs2  = 1'($urandom);
            e_wreg     = 1'($urandom);
            e_m2reg    = 1'($urandom);
            e_is_md    = ($urandom_range(0, 5) == 0);
            e_br_taken = ($urandom_range(0, 7) == 0);
            cycle();
        end
        chk("end_stall4", 64'(if1.stall_cnt), 64'(st4));
        chk("end_flush32", 64'(if0.flush_cnt), 64'(fl32));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
